// File: rtl/gf_pkg.sv
// Shared types and GF(2^m) alpha-stepping helpers for the discrete-log sequencer.
// The backward helper is used only when GF_LOG_BIDIR_EN is defined.
package gf_pkg;

    localparam int MAX_M = 16;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SEARCH = 2'd1,
        DONE   = 2'd2
    } state_t;

    function automatic int gf_order(input int m);
        return (1 << m) - 1;
    endfunction

    // Multiply by alpha modulo x^m + x^alpha + 1; bits at or above m stay zero.
    function automatic logic [MAX_M-1:0] step_fwd(input logic [MAX_M-1:0] b,
                                                  input int m, input int alpha);
        logic [MAX_M-1:0] r;
        logic             top;
        r   = '0;
        top = 1'b0;
        for (int i = 0; i < MAX_M; i++) begin
            if (i == m - 1) top = b[i];
        end
        for (int i = 1; i < MAX_M; i++) begin
            if (i < m) r[i] = b[i-1];
        end
        r[0] = top;
        for (int i = 1; i < MAX_M; i++) begin
            if (i == alpha) r[i] = r[i] ^ top;
        end
        return r;
    endfunction

    // Multiply by alpha^-1, the exact inverse of step_fwd.
    function automatic logic [MAX_M-1:0] step_bwd(input logic [MAX_M-1:0] b,
                                                  input int m, input int alpha);
        logic [MAX_M-1:0] r;
        logic             bot;
        r   = '0;
        bot = b[0];
        for (int i = 0; i < MAX_M - 1; i++) begin
            if (i < m - 1) r[i] = b[i+1];
        end
        for (int i = 0; i < MAX_M; i++) begin
            if (i == m - 1) r[i] = bot;
        end
        for (int i = 0; i < MAX_M; i++) begin
            if (i == alpha - 1) r[i] = r[i] ^ bot;
        end
        return r;
    endfunction

endpackage

// File: rtl/gf_log_seq_mul_alpha_inv.sv
// Combinational alpha^-1 stepper for the backward search register.
// Instantiated by gf_log_seq only when GF_LOG_BIDIR_EN is defined.
module mul_alpha_inv
    import gf_pkg::*;
#(
    parameter int PARAM_M     = 4,
    parameter int PARAM_ALPHA = 1
) (
    input  logic [PARAM_M-1:0] b,
    output logic [PARAM_M-1:0] r
);

    assign r = PARAM_M'(step_bwd(MAX_M'(b), PARAM_M, PARAM_ALPHA));

endmodule

// File: rtl/gf_log_seq.sv
// Sequential discrete logarithm over GF(2^PARAM_M): steps alpha^k until it equals the input.
// Define GF_LOG_BIDIR_EN to add a concurrent alpha^-k search from the top of the group.
//
//   state  | meaning
//   IDLE   | in_ready high, waiting for an element
//   SEARCH | stepping alpha-power register(s), comparing against x_reg
//   DONE   | result held on log_out/err_zero until out_ready
module gf_log_seq
    import gf_pkg::*;
#(
    parameter int PARAM_M     = 4,
    parameter int PARAM_ALPHA = 1
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [PARAM_M-1:0] in_1,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [PARAM_M-1:0] log_out,
    output logic               err_zero,
    output logic               busy
);

    localparam int                 N      = gf_order(PARAM_M);
    localparam logic [PARAM_M-1:0] ONE    = PARAM_M'(1);
    localparam logic [PARAM_M-1:0] K_LAST = PARAM_M'(N - 1);

    state_t             state, state_nxt;
    logic [PARAM_M-1:0] fwd, fwd_nxt, fwd_step;
    logic [PARAM_M-1:0] k, k_nxt;
    logic [PARAM_M-1:0] x_reg, x_nxt;
    logic [PARAM_M-1:0] log_nxt;
    logic               err_nxt, valid_nxt, busy_nxt;

    assign fwd_step = PARAM_M'(step_fwd(MAX_M'(fwd), PARAM_M, PARAM_ALPHA));

`ifdef GF_LOG_BIDIR_EN
    localparam logic [PARAM_M-1:0] BWD_INIT = PARAM_M'(step_bwd(MAX_M'(ONE), PARAM_M, PARAM_ALPHA));

    logic [PARAM_M-1:0] bwd, bwd_nxt, bwd_step;
    logic [PARAM_M-1:0] j, j_nxt;

    mul_alpha_inv #(
        .PARAM_M    (PARAM_M),
        .PARAM_ALPHA(PARAM_ALPHA)
    ) u_mul_alpha_inv (
        .b(bwd),
        .r(bwd_step)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            bwd <= '0;
            j   <= '0;
        end else begin
            bwd <= bwd_nxt;
            j   <= j_nxt;
        end
    end
`endif

    assign in_ready = (state == IDLE);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= IDLE;
            fwd       <= '0;
            k         <= '0;
            x_reg     <= '0;
            log_out   <= '0;
            err_zero  <= 1'b0;
            out_valid <= 1'b0;
            busy      <= 1'b0;
        end else begin
            state     <= state_nxt;
            fwd       <= fwd_nxt;
            k         <= k_nxt;
            x_reg     <= x_nxt;
            log_out   <= log_nxt;
            err_zero  <= err_nxt;
            out_valid <= valid_nxt;
            busy      <= busy_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        fwd_nxt   = fwd;
        k_nxt     = k;
        x_nxt     = x_reg;
        log_nxt   = log_out;
        err_nxt   = err_zero;
        valid_nxt = out_valid;
`ifdef GF_LOG_BIDIR_EN
        bwd_nxt   = bwd;
        j_nxt     = j;
`endif
        case (state)
            IDLE: begin
                if (in_valid) begin
                    x_nxt     = in_1;
                    fwd_nxt   = ONE;
                    k_nxt     = '0;
                    log_nxt   = '0;
                    err_nxt   = 1'b0;
                    valid_nxt = 1'b0;
`ifdef GF_LOG_BIDIR_EN
                    bwd_nxt   = BWD_INIT;
                    j_nxt     = K_LAST;
`endif
                    if (in_1 == '0) begin
                        // out_valid follows one cycle later so a zero has the same latency as alpha^0
                        err_nxt   = 1'b1;
                        state_nxt = DONE;
                    end else begin
                        state_nxt = SEARCH;
                    end
                end
            end
            SEARCH: begin
                if (fwd == x_reg) begin
                    log_nxt   = k;
                    valid_nxt = 1'b1;
                    state_nxt = DONE;
`ifdef GF_LOG_BIDIR_EN
                end else if (bwd == x_reg) begin
                    log_nxt   = j;
                    valid_nxt = 1'b1;
                    state_nxt = DONE;
`endif
                end else if (k == K_LAST) begin
                    log_nxt   = '0;
                    err_nxt   = 1'b1;
                    valid_nxt = 1'b1;
                    state_nxt = DONE;
                end else begin
                    fwd_nxt = fwd_step;
                    k_nxt   = k + ONE;
`ifdef GF_LOG_BIDIR_EN
                    bwd_nxt = bwd_step;
                    j_nxt   = j - ONE;
`endif
                end
            end
            DONE: begin
                if (!out_valid) begin
                    valid_nxt = 1'b1;
                end else if (out_ready) begin
                    valid_nxt = 1'b0;
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
        busy_nxt = (state_nxt == SEARCH);
    end

endmodule

// File: tb/tb_gf_log_seq.sv
// Self-checking bench for gf_log_seq (M=4, alpha=1) against a polynomial-arithmetic log table.
// Expected latencies follow GF_LOG_BIDIR_EN when the bench is built with it.
module tb_gf_log_seq;

    localparam int M    = 4;
    localparam int A    = 1;
    localparam int N    = (1 << M) - 1;
    localparam int POLY = (1 << M) | (1 << A) | 1;

    logic         clk = 1'b0;
    logic         rst = 1'b0;
    logic         in_valid = 1'b0;
    logic         in_ready;
    logic [M-1:0] in_1 = '0;
    logic         out_valid;
    logic         out_ready = 1'b0;
    logic [M-1:0] log_out;
    logic         err_zero;
    logic         busy;

    int checks = 0;
    int errors = 0;

    logic [M-1:0] pow_t [N];
    int           log_t [1 << M];

    gf_log_seq #(.PARAM_M(M), .PARAM_ALPHA(A)) dut (
        .clk      (clk),
        .rst      (rst),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .in_1     (in_1),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .log_out  (log_out),
        .err_zero (err_zero),
        .busy     (busy)
    );

    always #5 clk = ~clk;

    function automatic int exp_lat(input int e);
`ifdef GF_LOG_BIDIR_EN
        return ((e < N - 1 - e) ? e : N - 1 - e) + 1;
`else
        return e + 1;
`endif
    endfunction

    task automatic build_tables();
        int v;
        v = 1;
        for (int e = 0; e < N; e++) begin
            pow_t[e] = M'(v);
            log_t[v] = e;
            v = v << 1;
            if ((v & (1 << M)) != 0) v = v ^ POLY;
        end
    endtask

    // Submit x, wait (bounded) for out_valid, then hold the result for 'stall' cycles before taking it.
    task automatic do_txn(input logic [M-1:0] x, input int stall, output int lat,
                          output logic [M-1:0] lg, output logic ez, output logic saw_busy);
        @(negedge clk);
        in_1     = x;
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        in_1     = M'($urandom);
        lat      = 0;
        saw_busy = busy;
        while (!out_valid && lat < 40) begin
            @(posedge clk);
            #1;
            lat++;
            if (busy) saw_busy = 1'b1;
        end
        lg = log_out;
        ez = err_zero;
        repeat (stall) @(posedge clk);
        #1;
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b0;
        #12;
        checks++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0 || busy !== 1'b0 ||
            log_out !== '0 || err_zero !== 1'b0) begin
            errors++;
            $display("FAIL reset_state: got rdy=%b vld=%b busy=%b log=%0d err=%b, expected 1 0 0 0 0",
                     in_ready, out_valid, busy, log_out, err_zero);
        end
        @(negedge clk);
        rst = 1'b1;
        #1;
        checks++;
        if (in_ready !== 1'b1) begin
            errors++;
            $display("FAIL reset_release_ready: got %b expected 1", in_ready);
        end
    endtask

    task automatic test_directed();
        logic [M-1:0] xs [4];
        int           lat;
        logic [M-1:0] lg;
        logic         ez, sb;
        int           e;
        xs[0] = 4'b0001;
        xs[1] = 4'b0011;
        xs[2] = 4'b1001;
        xs[3] = 4'b0000;
        for (int t = 0; t < 4; t++) begin
            do_txn(xs[t], 0, lat, lg, ez, sb);
            if (xs[t] == '0) begin
                checks++;
                if (ez !== 1'b1 || lg !== '0 || lat != 1 || sb !== 1'b0) begin
                    errors++;
                    $display("FAIL zero_input: got err=%b log=%0d lat=%0d busy_seen=%b, expected 1 0 1 0",
                             ez, lg, lat, sb);
                end
            end else begin
                e = log_t[xs[t]];
                checks++;
                if (ez !== 1'b0 || lg !== M'(e) || lat != exp_lat(e)) begin
                    errors++;
                    $display("FAIL directed x=%0d: got log=%0d err=%b lat=%0d, expected log=%0d err=0 lat=%0d",
                             xs[t], lg, ez, lat, e, exp_lat(e));
                end
            end
        end
    endtask

    task automatic test_stall();
        int           e, lat;
        logic [M-1:0] x, lg;
        logic         ez, sb;
        e = $urandom_range(1, N - 1);
        x = pow_t[e];
        @(negedge clk);
        in_1     = x;
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        lat = 0;
        while (!out_valid && lat < 40) begin
            @(posedge clk);
            #1;
            lat++;
        end
        checks++;
        if (lat != exp_lat(e)) begin
            errors++;
            $display("FAIL stall_latency: got %0d expected %0d", lat, exp_lat(e));
        end
        for (int c = 0; c < 5; c++) begin
            @(posedge clk);
            #1;
            checks++;
            if (log_out !== M'(e) || out_valid !== 1'b1 || in_ready !== 1'b0) begin
                errors++;
                $display("FAIL stall_hold c=%0d: got log=%0d vld=%b rdy=%b, expected log=%0d 1 0",
                         c, log_out, out_valid, in_ready, e);
            end
        end
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        checks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            errors++;
            $display("FAIL stall_release: got vld=%b rdy=%b expected 0 1", out_valid, in_ready);
        end
        e = $urandom_range(0, N - 1);
        do_txn(pow_t[e], 0, lat, lg, ez, sb);
        checks++;
        if (lg !== M'(e) || ez !== 1'b0 || lat != exp_lat(e)) begin
            errors++;
            $display("FAIL after_stall: got log=%0d err=%b lat=%0d expected %0d 0 %0d",
                     lg, ez, lat, e, exp_lat(e));
        end
    endtask

    task automatic test_reset_mid_search();
        int           lat;
        logic [M-1:0] lg;
        logic         ez, sb;
        @(negedge clk);
        in_1     = pow_t[10];
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if (busy !== 1'b1) begin
            errors++;
            $display("FAIL mid_search_busy: got %b expected 1", busy);
        end
        rst = 1'b0;
        #1;
        checks++;
        if (out_valid !== 1'b0 || busy !== 1'b0 || log_out !== '0 || err_zero !== 1'b0 ||
            in_ready !== 1'b1) begin
            errors++;
            $display("FAIL mid_search_reset: got vld=%b busy=%b log=%0d err=%b rdy=%b, expected 0 0 0 0 1",
                     out_valid, busy, log_out, err_zero, in_ready);
        end
        @(negedge clk);
        rst = 1'b1;
        do_txn(pow_t[7], 0, lat, lg, ez, sb);
        checks++;
        if (lg !== 4'd7 || ez !== 1'b0 || lat != exp_lat(7)) begin
            errors++;
            $display("FAIL post_reset_log: got log=%0d err=%b lat=%0d expected 7 0 %0d",
                     lg, ez, lat, exp_lat(7));
        end
    endtask

    task automatic test_sweep();
        logic [M-1:0] order [N];
        logic [M-1:0] tmp;
        int           r, lat;
        logic [M-1:0] lg;
        logic         ez, sb;
        for (int i = 0; i < N; i++) order[i] = M'(i + 1);
        for (int i = N - 1; i > 0; i--) begin
            r        = $urandom_range(0, i);
            tmp      = order[i];
            order[i] = order[r];
            order[r] = tmp;
        end
        for (int i = 0; i < N; i++) begin
            do_txn(order[i], $urandom_range(0, 2), lat, lg, ez, sb);
            checks++;
            if (ez !== 1'b0 || int'(lg) >= N || pow_t[int'(lg) % N] !== order[i] ||
                lat != exp_lat(log_t[order[i]])) begin
                errors++;
                $display("FAIL sweep x=%0d: got log=%0d err=%b lat=%0d, expected log=%0d err=0 lat=%0d",
                         order[i], lg, ez, lat, log_t[order[i]], exp_lat(log_t[order[i]]));
            end
        end
    endtask

    task automatic test_random_stream();
        logic [M-1:0] x, lg;
        int           lat, el, e;
        logic         ez, sb;
        for (int t = 0; t < 12; t++) begin
            x = M'($urandom_range(0, N));
            do_txn(x, $urandom_range(0, 3), lat, lg, ez, sb);
            e  = (x == '0) ? 0 : log_t[x];
            el = (x == '0) ? 1 : exp_lat(e);
            checks++;
            if (ez !== (x == '0) || lg !== M'(e) || lat != el) begin
                errors++;
                $display("FAIL random x=%0d: got log=%0d err=%b lat=%0d, expected log=%0d err=%b lat=%0d",
                         x, lg, ez, lat, e, (x == '0), el);
            end
        end
    endtask

    initial begin
        build_tables();
        test_reset();
        test_directed();
        test_stall();
        test_reset_mid_search();
        test_sweep();
        test_random_stream();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/gf_log_seq.md
# gf_log_seq

Sequential discrete-logarithm unit for GF(2^PARAM_M), built on the primitive polynomial x^PARAM_M + x^PARAM_ALPHA + 1. It is the inverse direction of the alpha-power stepping register used by the GF multipliers: given a field element x, it returns k such that x = alpha^k. The search steps an alpha-power register once per cycle and stops on a match. It sits beside the syndrome/locator datapaths in the code-based accelerators and converts elements to exponent form for log-domain arithmetic.

## Interface
- PARAM_M, 4, field degree; elements and exponents are PARAM_M bits wide.
- PARAM_ALPHA, 1, middle tap of the primitive polynomial; 1 ≤ PARAM_ALPHA < PARAM_M.
- clk  input  1  rising-edge clock; the only clock.
- rst  input  1  asynchronous, active-low reset.
- in_valid  input  1  in_1 holds a valid element.
- in_ready  output  1  unit accepts input; high only in IDLE.
- in_1  input  PARAM_M  element x, polynomial basis, bit i = coefficient of alpha^i.
- out_valid  output  1  result valid; held until taken.
- out_ready  input  1  consumer takes the result.
- log_out  output  PARAM_M  exponent k, 0 ≤ k ≤ 2^PARAM_M−2.
- err_zero  output  1  input was 0 (log undefined); valid with out_valid.
- busy  output  1  high in SEARCH.

## Operation
- The group order is N = 2^PARAM_M − 1.
- Forward step, b·alpha: new[0]=b[M−1]; new[ALPHA]=b[ALPHA−1]^b[M−1]; all other bits new[i]=b[i−1].
- States are IDLE, SEARCH and DONE.
- IDLE: in_ready=1. On in_valid, latch x into x_reg and take one of two paths.
  - If x=0: go to DONE with err_zero=1 and log_out=0.
  - Otherwise: go to SEARCH with fwd=1 (alpha^0) and k=0.
- SEARCH, each cycle:
  - If fwd==x_reg: go to DONE with log_out=k.
  - Otherwise: fwd←fwd·alpha and k←k+1.
  - For a primitive polynomial the search always ends with k ≤ N−1.
  - Guard: if k reaches N−1 without a match, go to DONE with err_zero=1. This covers an illegal non-primitive configuration.
- DONE: out_valid=1. log_out and err_zero are stable. Return to IDLE on out_ready.
- Input is ignored outside IDLE. A new input can be accepted in the cycle after DONE clears.
- Asynchronous reset at any time, including mid-SEARCH, gives:
  - state IDLE;
  - fwd, k, x_reg, log_out, err_zero, out_valid and busy all 0;
  - in_ready=1 as soon as reset is released.

## Timing
- Acceptance edge is e0.
- For x=alpha^k, out_valid rises at edge e0+k+1.
- Zero input: out_valid at e0+1.
- Worst case without the macro: N edges after acceptance.
- Throughput: one result per (latency + 1 + consumer stall) cycles; no overlap.
- All outputs are registered and there is no combinational input→output path, except that in_ready is decoded from state only.

## Configuration
- Macro GF_LOG_BIDIR_EN.
- Defined: adds a backward register bwd, initialised to alpha^−1, with counter j=N−1. Each SEARCH cycle it steps bwd←bwd·alpha^−1 and j←j−1.
  - Backward step: new[i−1]=b[i] for i≥1; new[M−1]=b[0]; new[ALPHA−1]^=b[0].
  - A match on either register ends the search. If both match in the same cycle, the forward result k wins.
  - Latency becomes min(k, N−1−k)+1.
- Undefined: forward search only; no backward logic is synthesised.

## Structure
- Package gf_pkg holds:
  - the state enum (IDLE, SEARCH, DONE);
  - the N localparam function;
  - the forward and backward step functions, parameterised by PARAM_M and PARAM_ALPHA.
- One sub-module, mul_alpha_inv: a combinational alpha^−1 stepper. It is instantiated only under GF_LOG_BIDIR_EN.

## Test plan
- M=4, ALPHA=1, x=4'b0001 → log_out=0, out_valid at e0+1, err_zero=0.
- x=4'b0011 (alpha^4) → log_out=4, out_valid at e0+5 with or without the macro.
- x=4'b1001 (alpha^14) → log_out=14. Without the macro at e0+15; with GF_LOG_BIDIR_EN at e0+1.
- x=0 → err_zero=1, log_out=0, out_valid at e0+1; check that no SEARCH cycle occurs.
- Hold out_ready=0 for 5 cycles in DONE → log_out stays stable and in_ready stays 0. Then pulse out_ready → IDLE, and the next input is accepted.
- Assert rst mid-SEARCH (x=alpha^10, cycle 3) → all outputs go to 0 immediately. After release, x=alpha^7 → log_out=7.
- Sweep all 15 nonzero elements and check alpha^log_out==x.
